dma_copy: RTL and testbench
===========================

DMA_COPY -- requirements
Module: dma_copy

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  system clock; all state changes on the rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 cs  in  1  register-port select.
REQ-005 rw  in  1  register-port direction: 1 = read, 0 = write.
REQ-006 AD  in  3  register index.
REQ-007 DI  in  8  register write data.
REQ-008 DO  out  8  register read data; combinational from AD, independent of cs.
REQ-009 bus_req  out  1  request for bus ownership.
REQ-010 bus_gnt  in  1  ownership granted; the arbiter holds it high until bus_req falls.
REQ-011 m_address  out  16  initiator address.
REQ-012 m_dout  out  8  initiator write data.
REQ-013 m_din  in  8  initiator read data; synchronous memory, so data is valid the cycle after the address.
REQ-014 m_read  out  1  initiator direction: 1 = read, 0 = write.
REQ-015 intr  out  1  level interrupt.

Function
REQ-016 Register write: when cs=1 and rw=0, the selected register SHALL update at the rising edge.
REQ-017 Register map:
- 0/1: SRC low/high.
- 2/3: DST low/high.
- 4/5: CNT low/high.
- 6: CTRL/STATUS.
- 7: DONE_CLR.
REQ-018 CTRL write bits:
- bit0 = start.
- bit1 = ie (interrupt enable, stored).
- bit7 = abort.
REQ-019 STATUS read value: {1'b0, done, 4'b0, ie, busy}.
REQ-020 Register 7 SHALL read as 0x00; any write to it clears done.
REQ-021 SRC, DST and CNT SHALL read back live values. Writes to them while busy=1 SHALL be ignored.
REQ-022 States: IDLE, REQ, RD_ADDR, RD_DATA, WR.
REQ-023 IDLE with start=1:
- CNT=0: set done, stay in IDLE, no bus activity.
- CNT≠0: set busy and go to REQ.
REQ-024 Start written while busy=1 SHALL be ignored.
REQ-025 REQ: drive bus_req=1; move to RD_ADDR in the cycle after bus_gnt is sampled high. bus_req SHALL stay 1 from REQ until the transfer ends.
REQ-026 RD_ADDR: m_address=SRC, m_read=1, for 1 cycle.
REQ-027 RD_DATA: m_address=SRC, m_read=1; latch m_din into the data register at the end of the cycle; 1 cycle.
REQ-028 WR: m_address=DST, m_dout=data register, m_read=0, for 1 cycle.
REQ-029 At the end of WR: SRC+=1, DST+=1, CNT-=1.
- If new CNT≠0, go to RD_ADDR.
- Otherwise go to IDLE with busy=0, done=1, bus_req=0.
REQ-030 Throughput SHALL be exactly 3 cycles per byte after grant.
REQ-031 SRC and DST SHALL wrap 0xFFFF→0x0000 with 16-bit modulo arithmetic and no flag.
REQ-032 Abort (CTRL bit7=1) in any non-IDLE state SHALL, at that edge:
- return to IDLE with busy=0 and bus_req=0;
- suppress any pending write;
- leave done unchanged;
- freeze SRC/DST/CNT at their current values.
REQ-033 Abort and start in the same write: abort wins when busy=1; start is honoured when idle.
REQ-034 A DONE_CLR write in the same cycle that done is being set: the set wins.
REQ-035 Outside RD_ADDR/RD_DATA/WR, the initiator outputs SHALL be m_read=1, m_address=0x0000, m_dout=0x00.
REQ-036 intr SHALL equal done & ie, combinationally from registered state.

Reset
REQ-037 Reset SHALL force:
- state IDLE;
- busy=0, done=0, ie=0;
- SRC=DST=CNT=0x0000, data register 0x00;
- bus_req=0, m_read=1, m_address=0x0000, m_dout=0x00, intr=0.
REQ-038 Reset SHALL take priority over all register writes and over bus activity.
REQ-039 Reset asserted mid-transfer SHALL terminate the transfer with no further write cycle.

Verification
REQ-040 Copy 4 bytes:
- Stimulus: SRC=0x0800, DST=0x1000, CNT=4, CTRL=0x03, gnt tied high; memory at 0x0800..0x0803 = 11 22 33 44.
- Response: 0x1000..0x1003 = 11 22 33 44; busy=1 for 1+12 cycles; then done=1, intr=1, bus_req=0, CNT=0, SRC=0x0804.
REQ-041 Zero count:
- Stimulus: CNT=0, start.
- Response: done=1 next cycle; bus_req never asserted; m_read stays 1.
REQ-042 Wrap:
- Stimulus: SRC=0xFFFF, DST=0x0010, CNT=2.
- Response: reads 0xFFFF then 0x0000; final SRC=0x0001.
REQ-043 Grant delay and busy writes:
- Stimulus: hold gnt low 5 cycles after start; write SRC=0x1234 while busy.
- Response: no m_read=0 cycle before grant; bus_req held high; SRC write ignored.
REQ-044 Abort:
- Stimulus: CNT=8; write CTRL=0x80 during the 3rd byte's RD_DATA.
- Response: exactly 2 bytes written; busy=0, done=0; CNT=6.
REQ-045 Reset mid-transfer:
- Stimulus: rst=1 during WR.
- Response: next cycle m_read=1, bus_req=0, all registers 0x00.

Source files
------------

// File: rtl/dma_copy.sv
// Single-channel byte-copy DMA engine: register port for configuration, bus initiator that
// moves CNT bytes from SRC to DST at three cycles per byte once the bus is granted.
module dma_copy (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        rw,
  input  logic [2:0]  AD,
  input  logic [7:0]  DI,
  output logic [7:0]  DO,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] m_address,
  output logic [7:0]  m_dout,
  input  logic [7:0]  m_din,
  output logic        m_read,
  output logic        intr
);

  // state   | meaning
  // IDLE    | no transfer, bus released
  // REQ     | bus requested, waiting for grant
  // RD_ADDR | source address presented to memory
  // RD_DATA | source byte returned, captured at end of cycle
  // WR      | captured byte written to destination
  typedef enum logic [2:0] {IDLE, REQ, RD_ADDR, RD_DATA, WR} state_t;

  state_t      state, state_nxt;
  logic [15:0] src, dst, cnt;
  logic [7:0]  data_q;
  logic        done, ie;
  logic        busy, reg_wr, cfg_wr, ctrl_wr, start, abort, done_set;

  assign busy     = (state != IDLE);
  assign reg_wr   = cs & ~rw;
  assign cfg_wr   = reg_wr & ~busy;
  assign ctrl_wr  = reg_wr && (AD == 3'd6);
  assign start    = ctrl_wr & DI[0];
  assign abort    = ctrl_wr & DI[7] & busy;
  assign done_set = (~busy & start & (cnt == 16'd0)) |
                    ((state == WR) & ~abort & (cnt == 16'd1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && cnt != 16'd0) state_nxt = REQ;
      REQ:     if (bus_gnt) state_nxt = RD_ADDR;
      RD_ADDR: state_nxt = RD_DATA;
      RD_DATA: state_nxt = WR;
      WR:      state_nxt = (cnt == 16'd1) ? IDLE : RD_ADDR;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src    <= 16'h0000;
      dst    <= 16'h0000;
      cnt    <= 16'h0000;
      data_q <= 8'h00;
      done   <= 1'b0;
      ie     <= 1'b0;
    end else begin
      if (cfg_wr) begin
        case (AD)
          3'd0:    src[7:0]  <= DI;
          3'd1:    src[15:8] <= DI;
          3'd2:    dst[7:0]  <= DI;
          3'd3:    dst[15:8] <= DI;
          3'd4:    cnt[7:0]  <= DI;
          3'd5:    cnt[15:8] <= DI;
          default: ;
        endcase
      end
      if (ctrl_wr) ie <= DI[1];
      if (state == RD_DATA) data_q <= m_din;
      // An abort landing on the write cycle cancels that byte, so the pointers stay put.
      if (state == WR && !abort) begin
        src <= src + 16'd1;
        dst <= dst + 16'd1;
        cnt <= cnt - 16'd1;
      end
      if (done_set) done <= 1'b1;
      else if (reg_wr && AD == 3'd7) done <= 1'b0;
    end
  end

  always_comb begin
    m_read    = 1'b1;
    m_address = 16'h0000;
    m_dout    = 8'h00;
    case (state)
      RD_ADDR, RD_DATA: m_address = src;
      WR: if (!abort) begin
        m_read    = 1'b0;
        m_address = dst;
        m_dout    = data_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    DO = 8'h00;
    case (AD)
      3'd0:    DO = src[7:0];
      3'd1:    DO = src[15:8];
      3'd2:    DO = dst[7:0];
      3'd3:    DO = dst[15:8];
      3'd4:    DO = cnt[7:0];
      3'd5:    DO = cnt[15:8];
      3'd6:    DO = {1'b0, done, 4'b0000, ie, busy};
      default: DO = 8'h00;
    endcase
  end

  assign bus_req = busy;
  assign intr    = done & ie;

endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy: synchronous byte memory model on the initiator port,
// register-port stimulus, hand-computed expectations.
module tb_dma_copy;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic        rw = 1'b1;
  logic [2:0]  AD = 3'd0;
  logic [7:0]  DI = 8'h00;
  logic [7:0]  DO;
  logic        bus_req;
  logic        bus_gnt = 1'b1;
  logic [15:0] m_address;
  logic [7:0]  m_dout;
  logic [7:0]  m_din;
  logic        m_read;
  logic        intr;

  logic [7:0]  mem [0:65535];
  logic [7:0]  rd_q = 8'h00;
  logic        ld_en = 1'b0;
  logic [15:0] ld_addr = 16'h0000;
  logic [7:0]  ld_data = 8'h00;
  int          wr_total = 0;
  int          nogrant_wr = 0;

  int n_checks = 0;
  int n_errors = 0;

  dma_copy dut (
    .clk(clk), .rst(rst), .cs(cs), .rw(rw), .AD(AD), .DI(DI), .DO(DO),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .m_address(m_address), .m_dout(m_dout),
    .m_din(m_din), .m_read(m_read), .intr(intr)
  );

  always #5 clk = ~clk;

  assign m_din = rd_q;

  always @(posedge clk) begin
    rd_q <= mem[m_address];
    if (!m_read) begin
      mem[m_address] <= m_dout;
      wr_total <= wr_total + 1;
      if (!bus_gnt) nogrant_wr <= nogrant_wr + 1;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    @(negedge clk);
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    AD = a;
    #1;
    d = DO;
  endtask

  task automatic rd16(input logic [2:0] a, output logic [15:0] v);
    logic [7:0] lo, hi;
    rd(a, lo);
    rd(a + 3'd1, hi);
    v = {hi, lo};
  endtask

  task automatic load(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [15:0] c);
    reg_wr(3'd0, s[7:0]);  reg_wr(3'd1, s[15:8]);
    reg_wr(3'd2, d[7:0]);  reg_wr(3'd3, d[15:8]);
    reg_wr(3'd4, c[7:0]);  reg_wr(3'd5, c[15:8]);
  endtask

  task automatic wait_idle(input string tag);
    logic [7:0] s;
    int n;
    n = 0;
    rd(3'd6, s);
    while (s[0] && n < 200) begin
      n++;
      @(negedge clk);
      rd(3'd6, s);
    end
    check(tag, (n < 200), 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0]  v;
    logic [15:0] w;
    int n, ws, bad;

    repeat (2) @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      rd(a[2:0], v);
      check("rst_reg", v, 8'h00);
    end
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_m_read", m_read, 1'b1);
    check("rst_m_address", m_address, 16'h0000);
    check("rst_m_dout", m_dout, 8'h00);
    check("rst_intr", intr, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // copy 4 bytes
    load(16'h0800, 8'h11); load(16'h0801, 8'h22);
    load(16'h0802, 8'h33); load(16'h0803, 8'h44);
    setup(16'h0800, 16'h1000, 16'd4);
    reg_wr(3'd6, 8'h03);
    n = 0;
    rd(3'd6, v);
    while (v[0] && n < 100) begin
      n++;
      @(negedge clk);
      rd(3'd6, v);
    end
    check("copy_busy_cycles", n, 13);
    check("copy_mem0", mem[16'h1000], 8'h11);
    check("copy_mem1", mem[16'h1001], 8'h22);
    check("copy_mem2", mem[16'h1002], 8'h33);
    check("copy_mem3", mem[16'h1003], 8'h44);
    check("copy_status", v, 8'h42);
    check("copy_intr", intr, 1'b1);
    check("copy_bus_req", bus_req, 1'b0);
    rd16(3'd4, w); check("copy_cnt", w, 16'h0000);
    rd16(3'd0, w); check("copy_src", w, 16'h0804);
    rd16(3'd2, w); check("copy_dst", w, 16'h1004);
    rd(3'd7, v);   check("reg7_read", v, 8'h00);
    reg_wr(3'd7, 8'h5A);
    rd(3'd6, v);   check("done_clr_status", v, 8'h02);
    check("done_clr_intr", intr, 1'b0);

    // zero count
    reg_wr(3'd6, 8'h01);
    rd(3'd6, v);   check("zero_status", v, 8'h40);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_req || !m_read) bad++;
    end
    check("zero_no_bus", bad, 0);
    reg_wr(3'd7, 8'h00);

    // wrap
    load(16'hFFFF, 8'hA5); load(16'h0000, 8'h5A);
    setup(16'hFFFF, 16'h0010, 16'd2);
    reg_wr(3'd6, 8'h01);
    wait_idle("wrap_timeout");
    check("wrap_mem0", mem[16'h0010], 8'hA5);
    check("wrap_mem1", mem[16'h0011], 8'h5A);
    rd16(3'd0, w); check("wrap_src", w, 16'h0001);
    rd16(3'd2, w); check("wrap_dst", w, 16'h0012);
    reg_wr(3'd7, 8'h00);

    // grant delay and writes while busy
    load(16'h2000, 8'h77);
    setup(16'h2000, 16'h3000, 16'd1);
    bus_gnt = 1'b0;
    ws = wr_total;
    reg_wr(3'd6, 8'h01);
    check("gnt_bus_req0", bus_req, 1'b1);
    reg_wr(3'd0, 8'h34);
    check("gnt_bus_req1", bus_req, 1'b1);
    reg_wr(3'd1, 8'h12);
    repeat (2) @(negedge clk);
    check("gnt_bus_req2", bus_req, 1'b1);
    check("gnt_m_read", m_read, 1'b1);
    check("gnt_no_write", wr_total - ws, 0);
    rd16(3'd0, w); check("gnt_src_ignored", w, 16'h2000);
    bus_gnt = 1'b1;
    wait_idle("gnt_timeout");
    check("gnt_mem", mem[16'h3000], 8'h77);
    check("gnt_nogrant_wr", nogrant_wr, 0);
    rd16(3'd0, w); check("gnt_src_final", w, 16'h2001);
    reg_wr(3'd7, 8'h00);

    // abort during third byte's RD_DATA
    for (int i = 0; i < 8; i++) load(16'h4000 + 16'(i), 8'(i + 1));
    load(16'h5002, 8'hEE);
    setup(16'h4000, 16'h5000, 16'd8);
    ws = wr_total;
    reg_wr(3'd6, 8'h01);
    repeat (8) @(negedge clk);
    check("abort_at_rd_data", {m_read, m_address}, {1'b1, 16'h4002});
    reg_wr(3'd6, 8'h80);
    check("abort_writes", wr_total - ws, 2);
    check("abort_bus_req", bus_req, 1'b0);
    rd(3'd6, v);   check("abort_status", v, 8'h00);
    rd16(3'd4, w); check("abort_cnt", w, 16'd6);
    rd16(3'd0, w); check("abort_src", w, 16'h4002);
    rd16(3'd2, w); check("abort_dst", w, 16'h5002);
    repeat (5) @(negedge clk);
    check("abort_writes_after", wr_total - ws, 2);
    check("abort_mem0", mem[16'h5000], 8'h01);
    check("abort_mem1", mem[16'h5001], 8'h02);
    check("abort_mem2", mem[16'h5002], 8'hEE);

    // reset during WR
    setup(16'h6000, 16'h7000, 16'd3);
    reg_wr(3'd6, 8'h03);
    repeat (3) @(negedge clk);
    check("rst_mid_in_wr", m_read, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_m_read", m_read, 1'b1);
    check("rst_mid_bus_req", bus_req, 1'b0);
    check("rst_mid_intr", intr, 1'b0);
    for (int a = 0; a < 8; a++) begin
      rd(a[2:0], v);
      check("rst_mid_reg", v, 8'h00);
    end
    ws = wr_total;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_mid_no_write", wr_total - ws, 0);
    check("rst_mid_bus_idle", bus_req, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
